alu: RTL and testbench

- Parameterised integer ALU for the RISC-V datapath.
- Takes two WORDSIZE operands and a 4-bit operation code.
- Produces a result and a zero flag, registered on the clock: one-cycle latency.
- Sits between the register-file read stage and writeback/branch-compare logic.

---
 rtl/alu.sv | 115 +++++++++++
 tb/tb_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Integer ALU for the RISC-V datapath with a one-cycle registered result and zero flag.
// Define ALU_FLAGS_EN to add the registered N/C/V condition flags.
module alu #(
  parameter int unsigned WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORDSIZE-1:0] A,
  input  logic [WORDSIZE-1:0] B,
  input  logic [3:0]          CTL,
  output logic [WORDSIZE-1:0] R,
  output logic                Z
`ifdef ALU_FLAGS_EN
  ,
  output logic                N,
  output logic                C,
  output logic                V
`endif
);

  localparam int unsigned SHW = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [WORDSIZE-1:0] r_d, r_q;
  logic                z_d, z_q;
  logic [SHW-1:0]      shamt;
  logic [WORDSIZE-1:0] add_res, sub_res;

  assign shamt = B[SHW-1:0];

`ifdef ALU_FLAGS_EN
  logic n_d, n_q, c_d, c_q, v_d, v_q;
  logic add_co, sub_borrow;

  // Widened add/sub expose carry-out and borrow for the flag logic.
  assign {add_co, add_res}     = {1'b0, A} + {1'b0, B};
  assign {sub_borrow, sub_res} = {1'b0, A} - {1'b0, B};
`else
  assign add_res = A + B;
  assign sub_res = A - B;
`endif

  // Next result, zero flag and optional condition flags.
  always_comb begin
    r_d = '0;
    unique case (CTL)
      OP_AND:  r_d = A & B;
      OP_OR:   r_d = A | B;
      OP_ADD:  r_d = add_res;
      OP_XOR:  r_d = A ^ B;
      OP_SLL:  r_d = A << shamt;
      OP_SRL:  r_d = A >> shamt;
      OP_SUB:  r_d = sub_res;
      OP_SLT:  r_d = WORDSIZE'($signed(A) < $signed(B));
      OP_SRA:  r_d = WORDSIZE'($signed(A) >>> shamt);
      OP_SLTU: r_d = WORDSIZE'(A < B);
      OP_NOR:  r_d = ~(A | B);
      default: r_d = '0;
    endcase
    z_d = (r_d == '0);
`ifdef ALU_FLAGS_EN
    n_d = r_d[WORDSIZE-1];
    c_d = 1'b0;
    v_d = 1'b0;
    if (CTL == OP_ADD) begin
      c_d = add_co;
      v_d = (A[WORDSIZE-1] == B[WORDSIZE-1]) && (add_res[WORDSIZE-1] != A[WORDSIZE-1]);
    end else if (CTL == OP_SUB) begin
      c_d = ~sub_borrow;
      v_d = (A[WORDSIZE-1] != B[WORDSIZE-1]) && (sub_res[WORDSIZE-1] != A[WORDSIZE-1]);
    end
`endif
  end

  // Output registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      z_q <= 1'b1;
`ifdef ALU_FLAGS_EN
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
`endif
    end else begin
      r_q <= r_d;
      z_q <= z_d;
`ifdef ALU_FLAGS_EN
      n_q <= n_d;
      c_q <= c_d;
      v_q <= v_d;
`endif
    end
  end

  assign R = r_q;
  assign Z = z_q;
`ifdef ALU_FLAGS_EN
  assign N = n_q;
  assign C = c_q;
  assign V = v_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu at WORDSIZE=4; flag checks are built when ALU_FLAGS_EN is defined.
module tb_alu;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B, R;
  logic [3:0]   CTL;
  logic         Z;
`ifdef ALU_FLAGS_EN
  logic         N, C, V;
`endif

  alu #(.WORDSIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .CTL (CTL),
    .R   (R),
    .Z   (Z)
`ifdef ALU_FLAGS_EN
    ,
    .N   (N),
    .C   (C),
    .V   (V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    r;
    int    z;
    int    n;
    int    c;
    int    v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference result computed with plain integer arithmetic on 4-bit values.
  function automatic int model_r(input int ctl, input int a, input int b);
    int sh;
    sh = b % 4;
    case (ctl)
      0:  return a & b;
      1:  return a | b;
      2:  return (a + b) % 16;
      3:  return a ^ b;
      4:  return (a * (1 << sh)) % 16;
      5:  return a / (1 << sh);
      6:  return (a - b + 16) % 16;
      7:  return (sgn(a) < sgn(b)) ? 1 : 0;
      8:  return (sgn(a) >>> sh) & 15;
      9:  return (a < b) ? 1 : 0;
      12: return 15 - (a | b);
      default: return 0;
    endcase
  endfunction

  // One operation: drive, queue the expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input int ctl, input int a, input int b,
                      input int exp_r);
    exp_t e, g;
    int   s;
    rst = r;
    CTL = 4'(ctl);
    A   = 4'(a);
    B   = 4'(b);
    e.tag = tag;
    e.r   = r ? 0 : ((exp_r >= 0) ? exp_r : model_r(ctl, a, b));
    e.z   = (e.r == 0) ? 1 : 0;
    e.n   = r ? 0 : ((e.r >= 8) ? 1 : 0);
    e.c   = 0;
    e.v   = 0;
    if (!r && ctl == 2) begin
      e.c = (a + b > 15) ? 1 : 0;
      s   = sgn(a) + sgn(b);
      e.v = (s > 7 || s < -8) ? 1 : 0;
    end else if (!r && ctl == 6) begin
      e.c = (a >= b) ? 1 : 0;
      s   = sgn(a) - sgn(b);
      e.v = (s > 7 || s < -8) ? 1 : 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      check({g.tag, "_R"}, int'(R), g.r);
      check({g.tag, "_Z"}, int'(Z), g.z);
`ifdef ALU_FLAGS_EN
      check({g.tag, "_N"}, int'(N), g.n);
      check({g.tag, "_C"}, int'(C), g.c);
      check({g.tag, "_V"}, int'(V), g.v);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; CTL = 4'd3; A = 4'd9; B = 4'd6;
    #2;
    step("rst0", 1'b1, 3, 9, 6, 0);
    step("rst1", 1'b1, 2, 15, 15, 0);
    step("and75", 1'b0, 0, 7, 5, 5);
    step("or14", 1'b0, 1, 1, 4, 5);
    step("add32", 1'b0, 2, 3, 2, 5);
    step("sub55", 1'b0, 6, 5, 5, 0);
    step("and25", 1'b0, 0, 2, 5, 0);
    step("or36", 1'b0, 1, 3, 6, 7);
    step("sub25", 1'b0, 6, 2, 5, 13);
    step("add97", 1'b0, 2, 9, 7, 0);
    step("slt81", 1'b0, 7, 8, 1, 1);
    step("sltu81", 1'b0, 9, 8, 1, 0);
    step("nor00", 1'b0, 12, 0, 0, 15);
    step("sll32", 1'b0, 4, 3, 2, 12);
    step("srl122", 1'b0, 5, 12, 2, 3);
    step("sra81", 1'b0, 8, 8, 1, 12);
    step("sll15", 1'b0, 4, 1, 5, 2);
    step("xor", 1'b0, 3, 10, 6, 12);
    step("bad_op", 1'b0, 15, 7, 9, 0);
    step("add77", 1'b0, 2, 7, 7, 14);
    step("rst_mid", 1'b1, 2, 3, 2, 0);
    step("post_rst", 1'b0, 2, 3, 2, 5);
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'b0, $urandom_range(15), $urandom_range(15), $urandom_range(15), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
